alu_seq: RTL



---
 rtl/alu_seq_pkg.sv | 25 ++
 rtl/alu_seq_if.sv | 30 +++
 rtl/alu_seq_mul.sv | 47 ++++
 rtl/alu_seq.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared constants and FSM state type for the alu_seq command front-end.
package alu_seq_pkg;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_INV  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;
  localparam logic [2:0] ALU_XOR  = 3'd5;
  localparam logic [2:0] ALU_LESS = 3'd6;
  localparam logic [2:0] ALU_EQ   = 3'd7;

  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_MAX = 4'd9;
  localparam logic [3:0] OP_MIN = 4'd10;

  typedef enum logic [2:0] {
    StIdle,
    StExec,
    StMulStep,
    StSel,
    StResp
  } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Command, response and ALU-side signal bundle for alu_seq; slave is the block's view.
interface alu_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_func;
  logic [3:0] alu_result;
  logic       alu_z;
  logic       alu_l;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_result;
  logic       rsp_z;
  logic       rsp_l;
  logic       rsp_err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_result, alu_z, alu_l, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_func, rsp_valid, rsp_result, rsp_z, rsp_l, rsp_err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, alu_result, alu_z, alu_l, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_func, rsp_valid, rsp_result, rsp_z, rsp_l, rsp_err
  );
endinterface

// File: rtl/alu_seq_mul.sv
// Shift-add multiply helper: step counter, accumulator and operands for the next ADD issue.
module alu_seq_mul (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       active,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] alu_result,
  output logic [3:0] acc_next,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  output logic       last
);

  logic [1:0] step_q, step_d;
  logic [3:0] acc_q, acc_d;

  always_comb begin
    acc_d  = acc_q;
    step_d = step_q;
    if (start) begin
      acc_d  = '0;
      step_d = '0;
    end else if (active) begin
      acc_d  = alu_result;
      step_d = step_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      step_q <= '0;
    end else begin
      acc_q  <= acc_d;
      step_q <= step_d;
    end
  end

  // Operands are registered by the top, so they are formed for the step issued next cycle.
  assign acc_next = acc_d;
  assign op_a     = acc_d;
  assign op_b     = b[step_d] ? (a << step_d) : 4'd0;
  assign last     = active && (step_q == 2'd3);

endmodule

// File: rtl/alu_seq.sv
// Sequential command front-end for the 4-bit ALU; MUL is built only when ALU_SEQ_MUL_EN is defined.
module alu_seq
  import alu_seq_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  alu_seq_if.slave  bus
);

  state_e     state_q, state_d;
  logic [3:0] op_q, op_d, a_q, a_d, b_q, b_d;
  logic [3:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0] alu_func_q, alu_func_d;
  logic [3:0] res_q, res_d;
  logic       z_q, z_d, l_q, l_d, err_q, err_d;

`ifdef ALU_SEQ_MUL_EN
  logic       mul_start, mul_active, mul_last;
  logic [3:0] mul_in_a, mul_in_b, mul_acc_next, mul_op_a, mul_op_b;

  assign mul_start  = (state_q == StIdle) && bus.cmd_valid && (bus.cmd_op == OP_MUL);
  assign mul_active = (state_q == StMulStep);
  assign mul_in_a   = (state_q == StIdle) ? bus.cmd_a : a_q;
  assign mul_in_b   = (state_q == StIdle) ? bus.cmd_b : b_q;

  alu_seq_mul u_mul (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (mul_start),
    .active     (mul_active),
    .a          (mul_in_a),
    .b          (mul_in_b),
    .alu_result (bus.alu_result),
    .acc_next   (mul_acc_next),
    .op_a       (mul_op_a),
    .op_b       (mul_op_b),
    .last       (mul_last)
  );
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    alu_a_d    = '0;
    alu_b_d    = '0;
    alu_func_d = '0;
    res_d      = res_q;
    z_d        = z_q;
    l_d        = l_q;
    err_d      = err_q;
    case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          op_d = bus.cmd_op;
          a_d  = bus.cmd_a;
          b_d  = bus.cmd_b;
          if (!bus.cmd_op[3]) begin
            state_d    = StExec;
            alu_func_d = bus.cmd_op[2:0];
            alu_a_d    = bus.cmd_a;
            alu_b_d    = bus.cmd_b;
`ifdef ALU_SEQ_MUL_EN
          end else if (bus.cmd_op == OP_MUL) begin
            state_d    = StMulStep;
            alu_func_d = ALU_ADD;
            alu_a_d    = mul_op_a;
            alu_b_d    = mul_op_b;
`endif
          end else if (bus.cmd_op == OP_MAX || bus.cmd_op == OP_MIN) begin
            state_d    = StSel;
            alu_func_d = ALU_LESS;
            alu_a_d    = bus.cmd_a;
            alu_b_d    = bus.cmd_b;
          end else begin
            state_d = StResp;
            res_d   = '0;
            z_d     = 1'b0;
            l_d     = 1'b0;
            err_d   = 1'b1;
          end
        end
      end
      StExec: begin
        state_d = StResp;
        res_d   = bus.alu_result;
        z_d     = bus.alu_z;
        l_d     = bus.alu_l;
        err_d   = 1'b0;
      end
`ifdef ALU_SEQ_MUL_EN
      StMulStep: begin
        if (mul_last) begin
          state_d = StResp;
          res_d   = mul_acc_next;
          z_d     = (mul_acc_next == 4'd0);
          l_d     = 1'b0;
          err_d   = 1'b0;
        end else begin
          alu_func_d = ALU_ADD;
          alu_a_d    = mul_op_a;
          alu_b_d    = mul_op_b;
        end
      end
`endif
      StSel: begin
        state_d = StResp;
        z_d     = 1'b0;
        l_d     = bus.alu_l;
        err_d   = 1'b0;
        if (op_q == OP_MAX) res_d = bus.alu_l ? b_q : a_q;
        else                res_d = bus.alu_l ? a_q : b_q;
      end
      StResp: begin
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_func_q <= '0;
      res_q      <= '0;
      z_q        <= 1'b0;
      l_q        <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_func_q <= alu_func_d;
      res_q      <= res_d;
      z_q        <= z_d;
      l_q        <= l_d;
      err_q      <= err_d;
    end
  end

  // Gated by rst_n so every output reads 0 while reset is held.
  assign bus.cmd_ready  = rst_n && (state_q == StIdle);
  assign bus.rsp_valid  = (state_q == StResp);
  assign bus.rsp_result = res_q;
  assign bus.rsp_z      = z_q;
  assign bus.rsp_l      = l_q;
  assign bus.rsp_err    = err_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_func   = alu_func_q;

endmodule
